pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V pipeline; complements the forwarding unit by handling the hazards forwarding cannot resolve.
- Load-use hazards: one-cycle bubble.
- Taken branch/jump redirects: flush of D and E.
- Multi-cycle data-memory accesses: full-pipeline freeze through a ready handshake, with timeout watchdog.
Outputs drive the enable/clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

---
 rtl/pipeline_ctrl.sv | 139 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage RISC-V pipeline.
// Handles load-use bubbles, taken-branch redirects and multi-cycle data
// memory freezes. A watchdog halts the pipeline if memory never answers.
// Optional performance counters are enabled with `define PIPE_PERF_CNT_EN.
module pipeline_ctrl #(
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadE,
    input  logic [4:0]  RD_E,
    input  logic [4:0]  Rs1_D,
    input  logic [4:0]  Rs2_D,
    input  logic        PCSrcE,
    input  logic        MemReqM,
    input  logic        dmem_ready,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        mem_err,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             lu;
    logic             ms;

    // A load in E whose destination feeds D; x0 never creates a hazard.
    assign lu = MemReadE & (RD_E != 5'd0) & ((RD_E == Rs1_D) | (RD_E == Rs2_D));
    // Memory request in M that the data memory has not completed this cycle.
    assign ms = MemReqM & ~dmem_ready;

    // Memory-wait state machine with watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (ms) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= CNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (ms && (wait_cnt == CNT_W'(WAIT_MAX))) begin
                        state   <= HALT;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Prioritised stall/flush decode: reset, halt, freeze, branch, load-use.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (state == HALT) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (ms) begin
            // E is frozen, so branch and load-use are re-evaluated after release.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            // The D instruction is discarded, so any load-use on it is moot.
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lu) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // Performance counters: fetch-stall cycles and branch-induced flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 32'd0;
            flush_count  <= 32'd0;
        end else begin
            if (StallF) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (FlushD) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: table-driven directed bench for pipeline_ctrl, plus
// hand-written watchdog, reset and performance-counter sequences.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadE;
    logic [4:0]  RD_E;
    logic [4:0]  Rs1_D;
    logic [4:0]  Rs2_D;
    logic        PCSrcE;
    logic        MemReqM;
    logic        dmem_ready;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushW;
    logic        mem_err;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    int compared   = 0;
    int mismatched = 0;

    // Output vector order: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    localparam logic [6:0] O_IDLE   = 7'b0000_000;
    localparam logic [6:0] O_RESET  = 7'b0000_111;
    localparam logic [6:0] O_LU     = 7'b1100_010;
    localparam logic [6:0] O_BRANCH = 7'b0000_110;
    localparam logic [6:0] O_FREEZE = 7'b1111_001;

    typedef struct {
        logic       memReadE;
        logic [4:0] rdE;
        logic [4:0] rs1D;
        logic [4:0] rs2D;
        logic       pcSrcE;
        logic       memReqM;
        logic       dmemReady;
        logic [6:0] expOut;
        string      name;
    } vec_t;

    vec_t vecs[14];

    pipeline_ctrl #(.WAIT_MAX(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .MemReadE(MemReadE), .RD_E(RD_E), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .dmem_ready(dmem_ready),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge, settle before checking.
    task automatic applyStimulus(input logic r, input logic mr, input logic [4:0] rd,
                                 input logic [4:0] s1, input logic [4:0] s2,
                                 input logic pc, input logic mq, input logic dr);
        @(negedge clk);
        rst        = r;
        MemReadE   = mr;
        RD_E       = rd;
        Rs1_D      = s1;
        Rs2_D      = s2;
        PCSrcE     = pc;
        MemReqM    = mq;
        dmem_ready = dr;
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [6:0] expOut, input logic expErr);
        logic [7:0] act;
        act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err};
        compared++;
        if (act !== {expOut, expErr}) begin
            mismatched++;
            $display("[TB] FAIL %s: got stalls/flushes/err=%b required=%b", name, act, {expOut, expErr});
        end
    endtask

    task automatic checkCounters(input string name, input logic [31:0] expStall, input logic [31:0] expFlush);
        compared++;
        if (stall_cycles !== expStall || flush_count !== expFlush) begin
            mismatched++;
            $display("[TB] FAIL %s: got stall_cycles=%0d flush_count=%0d required %0d/%0d",
                     name, stall_cycles, flush_count, expStall, expFlush);
        end
    endtask

    // Global safety bound so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] pStall;
        logic [31:0] pFlush;
        // mr rd rs1 rs2 pc mq dr expected
        vecs[0]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_IDLE,   "idle"};
        vecs[1]  = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, O_LU,     "loaduse_rs2"};
        vecs[2]  = '{1'b0, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, O_IDLE,   "loaduse_after"};
        vecs[3]  = '{1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0, O_IDLE,   "x0_guard"};
        vecs[4]  = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, O_BRANCH, "branch_over_lu"};
        vecs[5]  = '{1'b1, 5'd7, 5'd7, 5'd2, 1'b0, 1'b0, 1'b0, O_LU,     "loaduse_rs1"};
        vecs[6]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, O_IDLE,   "mem_hit"};
        vecs[7]  = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, O_FREEZE, "wait1_masks_br"};
        vecs[8]  = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, O_FREEZE, "wait2_masks_br"};
        vecs[9]  = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, O_FREEZE, "wait3_masks_br"};
        vecs[10] = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, O_BRANCH, "release_branch"};
        vecs[11] = '{1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, O_FREEZE, "wait_masks_lu"};
        vecs[12] = '{1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, 1'b1, O_LU,     "release_lu"};
        vecs[13] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_IDLE,   "back_in_run"};

        // Reset state
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_outputs", O_RESET, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkCounters("reset_counters", 32'd0, 32'd0);

        // Table-driven sequence
        foreach (vecs[i]) begin
            applyStimulus(1'b0, vecs[i].memReadE, vecs[i].rdE, vecs[i].rs1D, vecs[i].rs2D,
                          vecs[i].pcSrcE, vecs[i].memReqM, vecs[i].dmemReady);
            checkOutput(vecs[i].name, vecs[i].expOut, 1'b0);
        end

        // Watchdog: one RUN cycle plus four MEM_WAIT cycles, then HALT
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            checkOutput("wd_waiting", O_FREEZE, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1);
        checkOutput("wd_halt_ready", O_FREEZE, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("wd_halt_idle", O_FREEZE, 1'b1);
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("wd_rst_high", O_RESET, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("wd_after_rst", O_IDLE, 1'b0);

        // Reset mid-MEM_WAIT returns to RUN
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("midwait_rst", O_RESET, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("midwait_run_branch", O_BRANCH, 1'b0);

        // Performance counters from a clean reset
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
        checkOutput("perf_lu", O_LU, 1'b0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            checkOutput("perf_wait", O_FREEZE, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("perf_release", O_IDLE, 1'b0);
`ifdef PIPE_PERF_CNT_EN
        pStall = 32'd4;
        pFlush = 32'd0;
`else
        pStall = 32'd0;
        pFlush = 32'd0;
`endif
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkCounters("perf_after_wait_lu", pStall, pFlush);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("perf_branch", O_BRANCH, 1'b0);
`ifdef PIPE_PERF_CNT_EN
        pFlush = 32'd1;
`endif
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkCounters("perf_after_branch", pStall, pFlush);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
